// File: rtl/opfetch_pkg.sv
// Shared definitions for the operand fetch stage: default data width,
// register address width and the fetch FSM state encoding.
package opfetch_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction that writes rd is accepted, cleared on writeback. Produces the
// RAW/WAW hazard for the instruction currently offered by the decoder.
// OPFETCH_FWD_EN: a RAW hazard is waived when the pending source is being
// written back in the same cycle, and the matching fwd_rsN_o flag is raised.
module opfetch_scoreboard
  import opfetch_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic                  use_rs1_i,
  input  logic                  use_rs2_i,
  input  logic                  writes_rd_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic                  hazard_o,
  output logic                  fwd_rs1_o,
  output logic                  fwd_rs2_o
);

  localparam int NADDR = 1 << REG_ADDR_W;

  logic [NREG-1:0]  pend_q, pend_d;
  logic [NADDR-1:0] pend_ext;
  logic             raw1, raw2, waw;

  // Pending bits: writeback clears, accepted writer sets; set applied last so it wins.
  always_comb begin
    pend_d = pend_q;
    for (int i = 1; i < NREG; i++) begin
      if (wb_valid_i && (wb_rd_i == REG_ADDR_W'(i))) pend_d[i] = 1'b0;
      if (set_en_i && (set_addr_i == REG_ADDR_W'(i))) pend_d[i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // Widen to the full address space so any 5-bit address can index it.
  always_comb begin
    pend_ext = '0;
    for (int i = 0; i < NREG; i++) pend_ext[i] = pend_q[i];
  end

  assign raw1 = use_rs1_i && (rs1_addr_i != '0) && pend_ext[rs1_addr_i];
  assign raw2 = use_rs2_i && (rs2_addr_i != '0) && pend_ext[rs2_addr_i];
  assign waw  = writes_rd_i && (rd_addr_i != '0) && pend_ext[rd_addr_i];

`ifdef OPFETCH_FWD_EN
  assign fwd_rs1_o = raw1 && wb_valid_i && (wb_rd_i == rs1_addr_i);
  assign fwd_rs2_o = raw2 && wb_valid_i && (wb_rd_i == rs2_addr_i);
`else
  assign fwd_rs1_o = 1'b0;
  assign fwd_rs2_o = 1'b0;
`endif

  assign hazard_o = (raw1 && !fwd_rs1_o) || (raw2 && !fwd_rs2_o) || waw;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts a decoded instruction when it is hazard free,
// reads the register file (one-cycle latency), and presents the operands to
// execute with a valid/ready handshake. Writeback passes straight through to
// the register file write port.
// OPFETCH_FWD_EN: writeback data seen in the accept cycle is forwarded in
// place of a stale register file read.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | waiting for a hazard-free decoder transfer
//   ST_RD   | register file data returning, operands latched
//   ST_OUT  | ex_valid high, held until ex_ready
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [REG_ADDR_W-1:0]  dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0]  dec_rs2_addr,
  input  logic [REG_ADDR_W-1:0]  dec_rd,
  input  logic                   dec_use_rs1,
  input  logic                   dec_use_rs2,
  input  logic                   dec_writes_rd,
  output logic [REG_ADDR_W-1:0]  rs1_addr,
  output logic [REG_ADDR_W-1:0]  rs2_addr,
  output logic                   read_rs1,
  output logic                   read_rs2,
  input  logic signed [XLEN-1:0] rs1,
  input  logic signed [XLEN-1:0] rs2,
  output logic [REG_ADDR_W-1:0]  rd,
  output logic [XLEN-1:0]        rd_data,
  output logic                   rd_write,
  input  logic                   wb_valid,
  input  logic [REG_ADDR_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [XLEN-1:0]        ex_rs1_data,
  output logic [XLEN-1:0]        ex_rs2_data,
  output logic [REG_ADDR_W-1:0]  ex_rd,
  output logic                   ex_writes_rd
);

  state_e                  state_q, state_d;
  logic                    transfer, hazard, fwd_rs1, fwd_rs2;
  logic                    zero1_q, zero2_q, fwd1_q, fwd2_q;
  logic [XLEN-1:0]         fwd_data_q;
  logic [XLEN-1:0]         ex_rs1_data_q, ex_rs2_data_q;
  logic [REG_ADDR_W-1:0]   ex_rd_q;
  logic                    ex_writes_rd_q;

  opfetch_scoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (transfer && dec_writes_rd),
    .set_addr_i (dec_rd),
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .rs1_addr_i (dec_rs1_addr),
    .rs2_addr_i (dec_rs2_addr),
    .use_rs1_i  (dec_use_rs1),
    .use_rs2_i  (dec_use_rs2),
    .writes_rd_i(dec_writes_rd),
    .rd_addr_i  (dec_rd),
    .hazard_o   (hazard),
    .fwd_rs1_o  (fwd_rs1),
    .fwd_rs2_o  (fwd_rs2)
  );

  assign transfer = dec_valid && dec_ready;

  assign rs1_addr = dec_rs1_addr;
  assign rs2_addr = dec_rs2_addr;
  assign read_rs1 = transfer && dec_use_rs1;
  assign read_rs2 = transfer && dec_use_rs2;

  assign rd       = wb_rd;
  assign rd_data  = wb_data;
  assign rd_write = wb_valid;

  assign ex_rs1_data  = ex_rs1_data_q;
  assign ex_rs2_data  = ex_rs2_data_q;
  assign ex_rd        = ex_rd_q;
  assign ex_writes_rd = ex_writes_rd_q;

  // Next state and handshake outputs; reset gates dec_ready so no read is issued.
  always_comb begin
    state_d   = state_q;
    dec_ready = 1'b0;
    ex_valid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        dec_ready = !hazard && !reset;
        if (dec_valid && dec_ready) state_d = ST_RD;
      end
      ST_RD:   state_d = ST_OUT;
      ST_OUT: begin
        ex_valid = 1'b1;
        if (ex_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Capture instruction fields at transfer, operand data in RD.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero1_q        <= 1'b0;
      zero2_q        <= 1'b0;
      fwd1_q         <= 1'b0;
      fwd2_q         <= 1'b0;
      fwd_data_q     <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_rd_q        <= '0;
      ex_writes_rd_q <= 1'b0;
    end else begin
      if (transfer) begin
        zero1_q        <= !dec_use_rs1 || (dec_rs1_addr == '0);
        zero2_q        <= !dec_use_rs2 || (dec_rs2_addr == '0);
        fwd1_q         <= fwd_rs1;
        fwd2_q         <= fwd_rs2;
        fwd_data_q     <= wb_data;
        ex_rd_q        <= dec_rd;
        ex_writes_rd_q <= dec_writes_rd;
      end
      if (state_q == ST_RD) begin
        ex_rs1_data_q <= zero1_q ? '0 : (fwd1_q ? fwd_data_q : rs1);
        ex_rs2_data_q <= zero2_q ? '0 : (fwd2_q ? fwd_data_q : rs2);
      end
    end
  end

endmodule
